// File: rtl/reg_bus_master.sv
// Single-outstanding command bridge from a valid/ready request/response pair to a
// strobe-based register bus, with read timeout and stray read-valid accounting.
module reg_bus_master #(
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic        s_clk,
  input  logic        poweron_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [3:0]  s_addr,
  output logic [15:0] s_wr_data,
  output logic        s_wr_en,
  output logic        s_rd_en,
  input  logic [15:0] s_rd_data,
  input  logic        s_rd_data_valid,
  output logic [7:0]  stray_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT_RD,
    RESP
  } state_t;

  // Last counter value still inside the read window; reaching it without valid times out.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        accept;

  logic        req_ready_nxt;
  logic        busy_nxt;
  logic [3:0]  s_addr_nxt;
  logic [15:0] s_wr_data_nxt;
  logic        s_wr_en_nxt;
  logic        s_rd_en_nxt;
  logic        rsp_valid_nxt;
  logic [15:0] rsp_data_nxt;
  logic        rsp_err_nxt;
  logic [7:0]  stray_cnt_nxt;

  // req_ready is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept = req_valid && req_ready;

  always_ff @(posedge s_clk) begin
    if (poweron_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = req_write ? WRITE : READ;
      WRITE:   state_nxt = RESP;
      READ:    state_nxt = WAIT_RD;
      WAIT_RD: if (s_rd_data_valid || (cnt == CNT_LAST)) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output; strobes and handshakes are
  // computed one cycle early so they appear exactly in the owning state.
  always_comb begin
    req_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
    rsp_valid_nxt = (state_nxt == RESP);
    s_addr_nxt    = s_addr;
    s_wr_data_nxt = s_wr_data;
    s_wr_en_nxt   = 1'b0;
    s_rd_en_nxt   = 1'b0;
    rsp_data_nxt  = rsp_data;
    rsp_err_nxt   = rsp_err;
    cnt_nxt       = cnt;
    stray_cnt_nxt = stray_cnt;

    if (s_rd_data_valid && (state != WAIT_RD) && (stray_cnt != 8'hFF)) begin
      stray_cnt_nxt = stray_cnt + 8'd1;
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          s_addr_nxt = req_addr;
          if (req_write) begin
            s_wr_data_nxt = req_wdata;
            s_wr_en_nxt   = 1'b1;
          end else begin
            s_rd_en_nxt   = 1'b1;
          end
        end
      end
      WRITE: begin
        rsp_data_nxt = '0;
        rsp_err_nxt  = 1'b0;
      end
      READ: begin
        cnt_nxt = '0;
      end
      WAIT_RD: begin
        if (s_rd_data_valid) begin
          rsp_data_nxt = s_rd_data;
          rsp_err_nxt  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          rsp_data_nxt = '0;
          rsp_err_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RESP: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (poweron_rst) begin
      req_ready <= 1'b0;
      busy      <= 1'b0;
      s_addr    <= '0;
      s_wr_data <= '0;
      s_wr_en   <= 1'b0;
      s_rd_en   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      stray_cnt <= '0;
    end else begin
      req_ready <= req_ready_nxt;
      busy      <= busy_nxt;
      s_addr    <= s_addr_nxt;
      s_wr_data <= s_wr_data_nxt;
      s_wr_en   <= s_wr_en_nxt;
      s_rd_en   <= s_rd_en_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_err   <= rsp_err_nxt;
      cnt       <= cnt_nxt;
      stray_cnt <= stray_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Randomized bench for reg_bus_master: a transaction-level model predicts strobe timing,
// response latency/contents and the saturating stray counter.
module tb_reg_bus_master;

  localparam int unsigned T = 8;

  logic        s_clk = 1'b0;
  logic        poweron_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  s_addr;
  logic [15:0] s_wr_data;
  logic        s_wr_en;
  logic        s_rd_en;
  logic [15:0] s_rd_data;
  logic        s_rd_data_valid;
  logic [7:0]  stray_cnt;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [3:0]  m_addr;
  logic [15:0] m_wdata;
  int unsigned m_stray;

  reg_bus_master #(.TIMEOUT_CYC(T)) dut (
    .s_clk           (s_clk),
    .poweron_rst     (poweron_rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .s_addr          (s_addr),
    .s_wr_data       (s_wr_data),
    .s_wr_en         (s_wr_en),
    .s_rd_en         (s_rd_en),
    .s_rd_data       (s_rd_data),
    .s_rd_data_valid (s_rd_data_valid),
    .stray_cnt       (stray_cnt),
    .busy            (busy)
  );

  always #5 s_clk = ~s_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge s_clk);
    #1;
  endtask

  function automatic logic [7:0] sat(input int unsigned v);
    logic [31:0] w;
    w = v;
    return (v > 255) ? 8'hFF : w[7:0];
  endfunction

  // Randomize inputs that must have no effect while a command is in flight.
  task automatic junk;
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = 4'($urandom);
    req_wdata = 16'($urandom);
    rsp_ready = 1'($urandom);
    s_rd_data = 16'($urandom);
  endtask

  task automatic idle_strays(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      s_rd_data_valid = 1'b1;
      s_rd_data       = 16'($urandom);
      tick;
      m_stray++;
    end
    s_rd_data_valid = 1'b0;
    check("stray_idle", stray_cnt, sat(m_stray));
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  // k: slave valid k cycles after s_rd_en (0 = never, i.e. timeout).
  // bp: cycles of rsp_ready=0 in RESP. sw: stray valid during WRITE. late: stray valid at RESP+2.
  task automatic do_cmd(input bit wr, input logic [3:0] a, input logic [15:0] d,
                        input int unsigned k, input int unsigned bp, input bit sw, input bit late);
    int unsigned n;
    int unsigned total;
    logic [15:0] rd;
    logic [15:0] exp_data;
    logic        exp_err;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = 1'($urandom);
    n = 0;
    while (!req_ready && n < 20) begin
      tick;
      n++;
    end
    check("accept_ready", req_ready, 1);
    tick;
    m_addr = a;
    if (wr) m_wdata = d;
    junk;
    s_rd_data_valid = 1'b0;
    check("strobe_wr", s_wr_en, wr);
    check("strobe_rd", s_rd_en, !wr);
    check("bus_addr", s_addr, m_addr);
    check("bus_wdata", s_wr_data, m_wdata);
    check("busy_cmd", busy, 1);
    check("ready_busy", req_ready, 0);
    if (wr) begin
      total = 0;
      if (sw) begin
        s_rd_data_valid = 1'b1;
        m_stray++;
      end
    end else begin
      total = (k == 0) ? T : k;
    end
    rd = 16'($urandom);
    for (int unsigned j = 1; j <= total; j++) begin
      tick;
      s_rd_data_valid = 1'b0;
      junk;
      if (k == j) begin
        s_rd_data_valid = 1'b1;
        s_rd_data       = rd;
      end
      check("wait_rsp_low", rsp_valid, 0);
      check("wait_no_strobe", {s_wr_en, s_rd_en}, 0);
      check("wait_addr", s_addr, m_addr);
    end
    tick;
    s_rd_data_valid = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    exp_data = (wr || k == 0) ? 16'h0000 : rd;
    exp_err  = !wr && (k == 0);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", rsp_err, exp_err);
    check("stray_cmd", stray_cnt, sat(m_stray));
    for (int unsigned b = 0; b < bp; b++) begin
      junk;
      rsp_ready = 1'b0;
      s_rd_data_valid = late && (b == 2);
      if (late && b == 2) m_stray++;
      tick;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, exp_data);
      check("bp_err", rsp_err, exp_err);
      check("bp_ready", req_ready, 0);
      check("bp_no_strobe", {s_wr_en, s_rd_en}, 0);
    end
    s_rd_data_valid = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("done_valid", rsp_valid, 0);
    check("done_busy", busy, 0);
    check("done_ready", req_ready, 1);
    check("done_stray", stray_cnt, sat(m_stray));
  endtask

  initial begin
    poweron_rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; s_rd_data = '0; s_rd_data_valid = 1'b0;
    m_addr = '0; m_wdata = '0; m_stray = 0;
    tick;
    tick;
    check("rst_outputs", {req_ready, busy, s_wr_en, s_rd_en, rsp_valid, rsp_err}, 0);
    check("rst_bus", {s_addr, s_wr_data}, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_stray", stray_cnt, 0);
    poweron_rst = 1'b0;
    tick;
    check("rst_exit_ready", req_ready, 1);

    do_cmd(1'b1, 4'h3, 16'hA5A5, 0, 0, 1'b0, 1'b0);
    do_cmd(1'b0, 4'h7, 16'h0000, 3, 0, 1'b0, 1'b0);
    do_cmd(1'b0, 4'h5, 16'hFFFF, 0, 3, 1'b0, 1'b1);
    do_cmd(1'b1, 4'h9, 16'h5A5A, 0, 5, 1'b1, 1'b0);
    do_cmd(1'b0, 4'hE, 16'h1111, 1, 1, 1'b0, 1'b0);
    do_cmd(1'b0, 4'h0, 16'h2222, T, 2, 1'b0, 1'b0);
    idle_strays(2);

    for (int unsigned i = 0; i < 40; i++) begin
      do_cmd(1'($urandom), 4'($urandom), 16'($urandom), $urandom_range(T, 0),
             $urandom_range(4, 0), 1'($urandom), 1'b0);
      idle_strays($urandom_range(2, 0));
    end

    // Reset while waiting for read data aborts the command silently.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'hB;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    poweron_rst = 1'b1;
    tick;
    poweron_rst = 1'b0;
    m_addr = '0; m_wdata = '0; m_stray = 0;
    check("rstw_busy", busy, 0);
    check("rstw_valid", rsp_valid, 0);
    check("rstw_ready", req_ready, 0);
    check("rstw_strobe", {s_wr_en, s_rd_en}, 0);
    check("rstw_stray", stray_cnt, 0);
    tick;
    check("rstw_ready_back", req_ready, 1);
    check("rstw_no_rsp", rsp_valid, 0);
    do_cmd(1'b0, 4'hB, 16'h0000, 2, 1, 1'b0, 1'b0);

    // Reset coinciding with acceptance must suppress the write strobe.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h4; req_wdata = 16'hBEEF;
    poweron_rst = 1'b1;
    tick;
    poweron_rst = 1'b0;
    req_valid = 1'b0;
    check("rsta_no_wr", s_wr_en, 0);
    check("rsta_busy", busy, 0);
    tick;
    check("rsta_no_wr2", s_wr_en, 0);
    check("rsta_wdata", s_wr_data, 0);
    do_cmd(1'b1, 4'h4, 16'hBEEF, 0, 0, 1'b0, 1'b0);

    idle_strays(300);
    do_cmd(1'b0, 4'h6, 16'h0000, 4, 1, 1'b0, 1'b0);
    idle_strays(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
